// File: rtl/f2f_conv_arbiter.sv
// rtl/f2f_conv_arbiter.sv - round-robin share of a pipelined fixed-to-float converter
// Tags follow each sample through the converter; a credit counter keeps the result FIFO from overflowing.
module f2f_conv_arbiter #(
  parameter int NUM_CH       = 4,
  parameter int FIXED_WIDTH  = 12,
  parameter int FLOAT_WIDTH  = 32,
  parameter int CONV_LATENCY = 4,
  parameter int FIFO_DEPTH   = 8,
  localparam int CH_W        = $clog2(NUM_CH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             req_valid,
  input  logic [NUM_CH*FIXED_WIDTH-1:0] req_data,
  output logic [NUM_CH-1:0]             req_ready,
  output logic [FIXED_WIDTH-1:0]        conv_a,
  input  logic [FLOAT_WIDTH-1:0]        conv_q,
  output logic                          res_valid,
  output logic [FLOAT_WIDTH-1:0]        res_data,
  output logic [CH_W-1:0]               res_ch,
  input  logic                          res_ready,
  output logic                          busy
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CR_W = $clog2(FIFO_DEPTH + 1);

  logic [CH_W-1:0]        ptr;
  logic [CH_W-1:0]        gidx;
  logic [NUM_CH-1:0]      grant;
  logic                   fire;
  logic [CR_W-1:0]        credit;
  logic [CONV_LATENCY:0]  tag_v;
  logic [CH_W-1:0]        tag_ch [0:CONV_LATENCY];
  logic [AW:0]            wr;
  logic [AW:0]            rd;
  logic                   empty;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic [FLOAT_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [CH_W-1:0]        mem_c [FIFO_DEPTH];

  // First valid channel at or after ptr wins; no grant without a free FIFO slot.
  always_comb begin
    int idx;
    logic found;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(ptr) + i) % NUM_CH;
      if (!found && req_valid[idx] && credit != '0 && rst_n) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = CH_W'(idx);
      end
    end
  end

  assign req_ready = grant;
  assign fire      = |grant;
  assign push      = tag_v[CONV_LATENCY];
  assign empty     = (wr == rd);
  assign full      = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign res_valid = !empty;
  assign pop       = res_valid & res_ready;
  assign res_data  = res_valid ? mem_d[rd[AW-1:0]] : '0;
  assign res_ch    = res_valid ? mem_c[rd[AW-1:0]] : '0;
  assign busy      = (credit != CR_W'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      conv_a <= '0;
      credit <= CR_W'(FIFO_DEPTH);
      tag_v  <= '0;
      wr     <= '0;
      rd     <= '0;
      for (int i = 0; i <= CONV_LATENCY; i++) tag_ch[i] <= '0;
    end else begin
      if (fire) begin
        conv_a <= req_data[gidx*FIXED_WIDTH +: FIXED_WIDTH];
        ptr    <= (gidx == CH_W'(NUM_CH - 1)) ? '0 : gidx + 1'b1;
      end
      tag_v[0]  <= fire;
      tag_ch[0] <= gidx;
      for (int i = 1; i <= CONV_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_ch[i] <= tag_ch[i-1];
      end
      case ({fire, pop})
        2'b10:   credit <= credit - 1'b1;
        2'b01:   credit <= credit + 1'b1;
        default: credit <= credit;
      endcase
      if (push) wr <= wr + 1'b1;
      if (pop)  rd <= rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_d[wr[AW-1:0]] <= conv_q;
      mem_c[wr[AW-1:0]] <= tag_ch[CONV_LATENCY];
    end
  end
endmodule

// File: tb/tb_f2f_conv_arbiter.sv
// tb/tb_f2f_conv_arbiter.sv - randomized bench with a queue-based reference model
module tb_f2f_conv_arbiter;
  localparam int N  = 4;
  localparam int FW = 12;
  localparam int L  = 4;
  localparam int D  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*FW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [FW-1:0]   conv_a;
  logic [31:0]     conv_q;
  logic            res_valid;
  logic [31:0]     res_data;
  logic [1:0]      res_ch;
  logic            res_ready;
  logic            busy;

  always #5 clk = ~clk;

  f2f_conv_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .conv_a(conv_a), .conv_q(conv_q), .res_valid(res_valid),
    .res_data(res_data), .res_ch(res_ch), .res_ready(res_ready), .busy(busy)
  );

  function automatic logic [31:0] fconv(input logic [FW-1:0] x);
    int v, a, m;
    v = int'($signed(x));
    a = (v < 0) ? -v : v;
    if (a == 0) return 32'h0;
    m = 0;
    for (int i = 0; i < FW; i++) if ((a >> i) != 0) m = i;
    return {(v < 0) ? 1'b1 : 1'b0, 8'(127 + m), 23'((a << (23 - m)) & 32'h7FFFFF)};
  endfunction

  // Converter stand-in: conv_a captured each edge, result on conv_q L edges later.
  logic [31:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= fconv(conv_a);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign conv_q = pipe[L-1];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int mptr = 0;
  int p_valid = 50;
  int p_ready = 70;
  int dut_fires = 0;
  int q_ch[$];
  int q_rdy[$];
  logic [31:0] q_dat[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    q_ch.delete();
    q_rdy.delete();
    q_dat.delete();
    mptr = 0;
  endtask

  task automatic gen(input int eg);
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] || i == eg) begin
        req_valid[i] = ($urandom_range(99) < p_valid);
        req_data[i*FW +: FW] = FW'($urandom);
      end
    end
    res_ready = ($urandom_range(99) < p_ready);
  endtask

  task automatic step();
    int eg, c;
    logic ev;
    logic [N-1:0] er;
    @(negedge clk);
    eg = -1;
    if (rst_n && q_ch.size() < D)
      for (int k = 0; k < N; k++) begin
        c = (mptr + k) % N;
        if (eg < 0 && req_valid[c]) eg = c;
      end
    er = '0;
    if (eg >= 0) er[eg] = 1'b1;
    chk("req_ready", req_ready, er);
    if (|req_ready) dut_fires++;
    ev = (q_ch.size() > 0) && (q_rdy[0] <= cyc);
    chk("res_valid", res_valid, ev);
    if (ev) begin
      chk("res_data", res_data, q_dat[0]);
      chk("res_ch", res_ch, q_ch[0]);
    end
    chk("busy", busy, q_ch.size() != 0);
    chk("no_overflow", dut.push & dut.full, 0);
    @(posedge clk);
    if (!rst_n) model_clear();
    else begin
      if (ev && res_ready) begin
        void'(q_ch.pop_front());
        void'(q_rdy.pop_front());
        void'(q_dat.pop_front());
      end
      if (eg >= 0) begin
        q_ch.push_back(eg);
        q_rdy.push_back(cyc + 2 + L);
        q_dat.push_back(fconv(req_data[eg*FW +: FW]));
        mptr = (eg + 1) % N;
      end
    end
    cyc++;
    #1;
    gen(eg);
  endtask

  task automatic one_sample(input int ch, input logic [FW-1:0] v, input logic [31:0] fexp);
    int n;
    p_valid = 0;
    p_ready = 100;
    req_valid = '0;
    req_valid[ch] = 1'b1;
    req_data[ch*FW +: FW] = v;
    n = cyc;
    step();
    chk("conv_a", conv_a, v);
    while (!res_valid && cyc < n + 20) step();
    chk("latency", cyc - n, 2 + L);
    chk("single_data", res_data, fexp);
    chk("single_ch", res_ch, ch);
    repeat (3) step();
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '1;
    req_data = {N{12'h123}};
    res_ready = 1'b0;
    model_clear();
    @(negedge clk);
    chk("rst_conv_a", conv_a, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_ch", res_ch, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    repeat (300) step();
    p_valid = 0; p_ready = 100;
    repeat (40) step();

    one_sample(2, 12'sd5, 32'h40A00000);
    one_sample(1, 12'h800, 32'hC5000000);

    req_valid = '1; p_valid = 100; p_ready = 100;
    repeat (40) step();

    p_valid = 0;
    repeat (30) step();
    req_valid = '1; p_valid = 100; p_ready = 0; res_ready = 1'b0;
    dut_fires = 0;
    repeat (20) step();
    chk("bp_fires", dut_fires, D);
    chk("bp_busy", busy, 1);
    chk("bp_ready", req_ready, 0);
    p_ready = 100; res_ready = 1'b1;
    repeat (2) step();
    chk("credit_boundary", |req_ready, 1);
    repeat (30) step();

    p_valid = 0; p_ready = 100;
    repeat (30) step();
    p_ready = 0; res_ready = 1'b0;
    repeat (5) begin
      req_valid = 4'b0001;
      step();
    end
    req_valid = '0;
    repeat (2) step();
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_busy", busy, 0);
    step();
    rst_n = 1'b1;
    req_valid = '1;
    req_data = {N{12'h07F}};
    #1;
    chk("midrst_grant_ch0", req_ready, 4'b0001);
    p_valid = 50; p_ready = 100;
    repeat (40) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
